// File: rtl/duke550_pkg.sv
// Shared definitions for the Duke 550 fetch / next-PC stage:
// opcode constants, instruction field positions and FSM state encoding.
package duke550_pkg;

    // Instruction field positions (32-bit instruction word)
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 27;
    localparam int OP_W    = OP_MSB - OP_LSB + 1;
    localparam int IMM_MSB = 16;
    localparam int IMM_W   = IMM_MSB + 1;
    localparam int TGT_MSB = 26;
    localparam int TGT_W   = TGT_MSB + 1;

    // Opcodes seen by this stage (decoded by control)
    localparam logic [4:0] OP_ALU   = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_INPUT = 5'b01110;

    // Per-instruction sequencer states
    typedef enum logic [1:0] {
        FETCH   = 2'b00,
        EXEC    = 2'b01,
        WAIT_IN = 2'b10
    } fetch_state_t;

    // Sign-extend the 17-bit branch immediate to 32 bits
    function automatic logic [31:0] imm_sext(input logic [31:0] w);
        return {{(32 - IMM_W){w[IMM_MSB]}}, w[IMM_MSB:0]};
    endfunction

    // Extract the 27-bit jump target
    function automatic logic [TGT_W-1:0] jump_tgt(input logic [31:0] w);
        return w[TGT_MSB:0];
    endfunction

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// Combinational next-PC selection: pc+1, branch target, jump target, JR.
// Ports: pc/insn/flags/ALU compares/rd_val in; pc_plus1, next_pc out.
module next_pc_sel
    import duke550_pkg::*;
#(
    parameter int PC_W   = 12,
    parameter int INSN_W = 32
) (
    input  logic [PC_W-1:0]   pc,
    input  logic [INSN_W-1:0] insn,
    input  logic              BR,
    input  logic              BGT,
    input  logic              JP,
    input  logic              JR,
    input  logic              JAL,
    input  logic              alu_ne,
    input  logic              alu_lt,
    input  logic [31:0]       rd_val,
    output logic [PC_W-1:0]   pc_plus1,
    output logic [PC_W-1:0]   next_pc
);

    logic [31:0]       imm_x;
    logic [TGT_W-1:0]  tgt;
    logic [PC_W-1:0]   br_tgt;
    logic              jump;
    logic              br_taken;

    assign imm_x    = imm_sext(32'(insn));
    assign tgt      = jump_tgt(32'(insn));
    assign pc_plus1 = pc + PC_W'(1);

    // Branch offset is relative to pc+1; truncation gives the
    // modulo-2^PC_W wrap for free in both directions.
    assign br_tgt   = pc_plus1 + imm_x[PC_W-1:0];

    // JAL is always issued with JP by control; accept either.
    assign jump     = JP | JAL;
    assign br_taken = (BR & alu_ne) | (BGT & alu_lt);

    always_comb begin
        next_pc = pc_plus1;
        if (JR)
            next_pc = rd_val[PC_W-1:0];
        else if (jump)
            next_pc = tgt[PC_W-1:0];
        else if (br_taken)
            next_pc = br_tgt;
    end

    // Bits beyond the PC width are architecturally ignored here.
    logic unused_bits;
    assign unused_bits = ^{insn, rd_val, imm_x, tgt};

endmodule

// File: rtl/fetch_unit.sv
// Duke 550 fetch stage: PC register, ROM addressing and FETCH/EXEC/WAIT_IN
// sequencing. Ports: clock/reset, imem_addr/imem_q ROM, insn/op/insn_valid
// to decode, control flags + ALU compares + rd_val in, keyboard handshake.
module fetch_unit
    import duke550_pkg::*;
#(
    parameter int PC_W   = 12,
    parameter int INSN_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INSN_W-1:0] imem_q,
    output logic [INSN_W-1:0] insn,
    output logic [4:0]        op,
    output logic              insn_valid,
    output logic [PC_W-1:0]   pc_plus1,
    input  logic              BR,
    input  logic              BGT,
    input  logic              JP,
    input  logic              JR,
    input  logic              JAL,
    input  logic              input_ack,
    input  logic              alu_ne,
    input  logic              alu_lt,
    input  logic [31:0]       rd_val,
    input  logic              kb_valid,
    output logic              kb_ack
);

    fetch_state_t    state;
    fetch_state_t    state_n;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_n;
    logic [PC_W-1:0] next_pc;

    // ROM address is the PC itself; holding pc holds imem_q.
    assign imem_addr = pc;
    assign insn      = imem_q;
    assign op        = imem_q[OP_MSB:OP_LSB];

    next_pc_sel #(
        .PC_W   (PC_W),
        .INSN_W (INSN_W)
    ) u_sel (
        .pc       (pc),
        .insn     (imem_q),
        .BR       (BR),
        .BGT      (BGT),
        .JP       (JP),
        .JR       (JR),
        .JAL      (JAL),
        .alu_ne   (alu_ne),
        .alu_lt   (alu_lt),
        .rd_val   (rd_val),
        .pc_plus1 (pc_plus1),
        .next_pc  (next_pc)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            pc    <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
        end
    end

    // Commit strobes are decoded from state, so an async reset
    // kills them in the same cycle it forces FETCH.
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        insn_valid = 1'b0;
        kb_ack     = 1'b0;
        unique case (state)
            FETCH: begin
                state_n = EXEC;
            end
            EXEC: begin
                if (input_ack && !kb_valid) begin
                    state_n = WAIT_IN;
                end else begin
                    insn_valid = 1'b1;
                    kb_ack     = input_ack;
                    pc_n       = next_pc;
                    state_n    = FETCH;
                end
            end
            WAIT_IN: begin
                if (kb_valid) begin
                    insn_valid = 1'b1;
                    kb_ack     = 1'b1;
                    pc_n       = pc_plus1;
                    state_n    = FETCH;
                end
            end
            default: begin
                state_n = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: ROM + control model, instruction-level
// reference model feeding a scoreboard checked by a commit monitor.
module tb_fetch_unit;

    localparam int OP_J     = 1;
    localparam int OP_BNE   = 2;
    localparam int OP_JAL   = 3;
    localparam int OP_JR    = 4;
    localparam int OP_BLT   = 6;
    localparam int OP_INPUT = 14;
    localparam int NPC      = 4096;

    logic        clock;
    logic        reset;
    logic [11:0] imem_addr;
    logic [31:0] imem_q;
    logic [31:0] insn;
    logic [4:0]  op;
    logic        insn_valid;
    logic [11:0] pc_plus1;
    logic        BR, BGT, JP, JR, JAL, input_ack;
    logic        alu_ne, alu_lt;
    logic [31:0] rd_val;
    logic        kb_valid;
    logic        kb_ack;
    logic        xjp;

    logic [31:0] mem [NPC];

    fetch_unit #(.PC_W(12), .INSN_W(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_q     (imem_q),
        .insn       (insn),
        .op         (op),
        .insn_valid (insn_valid),
        .pc_plus1   (pc_plus1),
        .BR         (BR),
        .BGT        (BGT),
        .JP         (JP),
        .JR         (JR),
        .JAL        (JAL),
        .input_ack  (input_ack),
        .alu_ne     (alu_ne),
        .alu_lt     (alu_lt),
        .rd_val     (rd_val),
        .kb_valid   (kb_valid),
        .kb_ack     (kb_ack)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Synchronous ROM
    always @(posedge clock) imem_q <= mem[imem_addr];

    // Control model: flags decoded from op; xjp forces an extra JP
    always_comb begin
        JR        = (op == 5'(OP_JR));
        JAL       = (op == 5'(OP_JAL));
        JP        = (op == 5'(OP_J)) || (op == 5'(OP_JAL)) || xjp;
        BR        = (op == 5'(OP_BNE));
        BGT       = (op == 5'(OP_BLT));
        input_ack = (op == 5'(OP_INPUT));
    end

    typedef struct {
        int          pc;
        logic [31:0] w;
        int          pc1;
        int          nxt;
        logic        kb;
        int          gap;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   model_pc;

    task automatic chk(input string nm, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [31:0] mk(input int o, input int low);
        logic [4:0]  ob;
        logic [26:0] lb;
        ob = 5'(o);
        lb = 27'(low);
        return {ob, lb};
    endfunction

    // Reference: instruction-level next PC from the priority rules
    function automatic int model_next(input int pc, input logic [31:0] w,
                                      input bit ne, input bit lt,
                                      input logic [31:0] rd, input bit fj);
        int o;
        int imm;
        o   = int'(w[31:27]);
        imm = int'(w[16:0]);
        if (w[16]) imm -= 131072;
        if (o == OP_JR) return int'(rd & 32'hFFF);
        if (o == OP_J || o == OP_JAL || fj) return int'(w[26:0]) % NPC;
        if ((o == OP_BNE && ne) || (o == OP_BLT && lt))
            return (((pc + 1 + imm) % NPC) + NPC) % NPC;
        return (pc + 1) % NPC;
    endfunction

    // Monitor: checks every commit against the scoreboard head
    int   cnt;
    bit   pend;
    int   pend_pc;
    exp_t e;

    always @(negedge clock) begin
        if (reset) begin
            cnt  = 0;
            pend = 0;
        end else begin
            cnt++;
            if (pend) begin
                chk("next_pc", imem_addr, pend_pc);
                pend = 0;
            end
            if (kb_ack && !insn_valid)
                chk("kb_ack_without_commit", kb_ack, 0);
            if (insn_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_commit", insn_valid, 0);
                end else begin
                    e = q.pop_front();
                    chk("commit_pc", imem_addr, e.pc);
                    chk("commit_insn", insn, e.w);
                    chk("commit_op", op, e.w[31:27]);
                    chk("pc_plus1", pc_plus1, e.pc1);
                    chk("kb_ack", kb_ack, e.kb);
                    chk("commit_gap", cnt, e.gap);
                    pend    = 1;
                    pend_pc = e.nxt;
                end
                cnt = 0;
            end
        end
    end

    // Driver: one instruction per call, entered in its FETCH cycle
    task automatic do_insn(input bit ne, input bit lt,
                           input logic [31:0] rd, input int stall,
                           input bit fj);
        exp_t x;
        bit   is_in;
        bit   seen;
        int   n;
        x.pc  = model_pc;
        x.w   = mem[model_pc];
        is_in = (int'(x.w[31:27]) == OP_INPUT);
        if (is_in) fj = 0;
        if (!is_in) stall = 0;
        x.pc1 = (model_pc + 1) % NPC;
        x.nxt = model_next(model_pc, x.w, ne, lt, rd, fj);
        x.kb  = is_in;
        x.gap = 2 + stall;
        q.push_back(x);
        alu_ne = ne;
        alu_lt = lt;
        rd_val = rd;
        xjp    = fj;
        if (is_in) begin
            kb_valid = 1'b0;
            repeat (stall + 1) @(posedge clock);
            #1 kb_valid = 1'b1;
        end else begin
            kb_valid = 1'($urandom);
        end
        seen = 0;
        n    = 0;
        while (!seen && n < 40) begin
            @(negedge clock);
            seen = insn_valid;
            n++;
        end
        if (!seen) chk("commit_timeout", 0, 1);
        @(posedge clock);
        #1;
        kb_valid = 1'b0;
        xjp      = 1'b0;
        model_pc = x.nxt;
    endtask

    function automatic logic [31:0] rand_word();
        int r;
        int low;
        low = int'($urandom_range(0, 27'h7FFFFFF));
        r   = int'($urandom_range(0, 9));
        case (r)
            3:       return mk(OP_J, low);
            4:       return mk(OP_JAL, low);
            5:       return mk(OP_JR, low);
            6:       return mk(OP_BNE, low);
            7:       return mk(OP_BLT, low);
            8:       return mk(OP_INPUT, low);
            9:       return $urandom;
            default: return mk(0, low);
        endcase
    endfunction

    initial begin
        reset    = 1'b1;
        alu_ne   = 1'b0;
        alu_lt   = 1'b0;
        rd_val   = '0;
        kb_valid = 1'b0;
        xjp      = 1'b0;
        for (int i = 0; i < NPC; i++) mem[i] = '0;
        mem[3]     = mk(OP_J, 5);
        mem[5]     = mk(OP_BNE, 17'h1FFFD);
        mem[6]     = mk(OP_JR, 0);
        mem[12'h234] = mk(OP_J, 10);
        mem[10]    = mk(OP_JAL, 100);
        mem[100]   = mk(OP_J, 7);
        mem[7]     = mk(OP_INPUT, 0);
        mem[8]     = mk(OP_J, 4095);
        mem[4095]  = mk(0, 123);

        repeat (2) @(posedge clock);
        #1;
        chk("reset_addr", imem_addr, 0);
        chk("reset_valid", insn_valid, 0);
        chk("reset_kb_ack", kb_ack, 0);
        reset    = 1'b0;
        model_pc = 0;

        // Straight line, branches, JR over JP, JAL, input stall, wrap
        do_insn(0, 0, 0, 0, 0);
        do_insn(0, 0, 0, 0, 0);
        do_insn(0, 0, 0, 0, 0);
        do_insn(0, 0, 0, 0, 0);
        do_insn(1, 0, 0, 0, 0);
        do_insn(0, 0, 0, 0, 0);
        do_insn(0, 0, 0, 0, 0);
        do_insn(0, 0, 32'h1234, 0, 1);
        do_insn(0, 0, 0, 0, 0);
        do_insn(0, 0, 0, 0, 0);
        do_insn(0, 0, 0, 0, 0);
        do_insn(0, 0, 0, 5, 0);
        do_insn(0, 0, 0, 0, 0);
        do_insn(0, 0, 0, 0, 0);
        do_insn(0, 0, 0, 0, 0);

        // Reset in the middle of EXEC at pc=1
        @(posedge clock);
        #1;
        chk("pre_reset_addr", imem_addr, 1);
        reset = 1'b1;
        #1;
        chk("midexec_reset_addr", imem_addr, 0);
        chk("midexec_reset_valid", insn_valid, 0);
        chk("midexec_reset_kb_ack", kb_ack, 0);
        for (int i = 0; i < NPC; i++) mem[i] = rand_word();
        @(posedge clock);
        #1;
        reset    = 1'b0;
        model_pc = 0;

        for (int k = 0; k < 400; k++) begin
            do_insn(1'($urandom), 1'($urandom), $urandom,
                    int'($urandom_range(0, 3)),
                    ($urandom_range(0, 7) == 0));
        end

        chk("scoreboard_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
